switch_debouncer: RTL and testbench

Input-side conditioner for the board's DIP switches and pushbuttons. Each asynchronous, bouncing contact is synchronized into the 24 MHz internal-oscillator domain, filtered so that only levels held for a full debounce window are accepted, and then converted into a clean level plus single-cycle rise/fall pulses. LED and display logic consume only these outputs, never raw pins.

---
 rtl/switch_debouncer.sv | 107 ++++++++++
 tb/tb_switch_debouncer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Conditions asynchronous, bouncing switch/pushbutton contacts for use in the
//   clk domain. Each channel has its own 2-FF synchronizer, debounce counter
//   and two-state filter FSM. A new level is accepted only after it has been
//   seen on the synchronized input for DEBOUNCE_CYCLES consecutive cycles.
//   Accepted changes produce a clean level plus one-cycle rise/fall pulses.
//
// Parameters
//   WIDTH            number of independent switch channels
//   DEBOUNCE_CYCLES  cycles a new level must persist to be accepted (>= 2)
//
// Ports
//   clk         clock
//   reset       asynchronous, active-low reset
//   s_raw       raw switch pins, asynchronous to clk
//   s_clean     debounced, registered level per channel
//   s_rise      one-cycle pulse on s_clean 0 -> 1
//   s_fall      one-cycle pulse on s_clean 1 -> 0
//   any_change  registered OR of all rise/fall pulses, same cycle as them
module switch_debouncer #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 240000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_raw,
    output logic [WIDTH-1:0] s_clean,
    output logic [WIDTH-1:0] s_rise,
    output logic [WIDTH-1:0] s_fall,
    output logic             any_change
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE,
        SETTLING
    } state_t;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= s_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        state_t        state;
        logic [CW-1:0] cnt;
        logic          clean_q;
        logic          rise_q;
        logic          fall_q;

        // Counter can only reach CNT_MAX while SETTLING, so the state check
        // does not change behaviour; it keeps the acceptance tied to the FSM.
        assign accept[i] = (sync2[i] != clean_q) && (state == SETTLING)
                           && (cnt == CNT_MAX);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state   <= STABLE;
                cnt     <= '0;
                clean_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sync2[i] == clean_q) begin
                    // Bounce back to the old level restarts the window.
                    cnt   <= '0;
                    state <= STABLE;
                end else if (accept[i]) begin
                    clean_q <= sync2[i];
                    rise_q  <= sync2[i];
                    fall_q  <= ~sync2[i];
                    cnt     <= '0;
                    state   <= STABLE;
                end else begin
                    cnt   <= cnt + CW'(1);
                    state <= SETTLING;
                end
            end
        end

        assign s_clean[i] = clean_q;
        assign s_rise[i]  = rise_q;
        assign s_fall[i]  = fall_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |accept;
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer
//   Self-checking bench for switch_debouncer (WIDTH=4, DEBOUNCE_CYCLES=8).
//   Reference model: s_raw is seen by the filter two edges late; a channel
//   accepts a new level when the last DEBOUNCE_CYCLES filter samples all
//   differ from its current clean level.
module tb_switch_debouncer;

    localparam int unsigned W = 4;
    localparam int unsigned D = 8;

    logic         clk;
    logic         reset;
    logic [W-1:0] s_raw;
    logic [W-1:0] s_clean;
    logic [W-1:0] s_rise;
    logic [W-1:0] s_fall;
    logic         any_change;

    switch_debouncer #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_raw     (s_raw),
        .s_clean   (s_clean),
        .s_rise    (s_rise),
        .s_fall    (s_fall),
        .any_change(any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_fail;

    // Reference model state
    logic [W-1:0] m_r1, m_r2;          // raw samples from 1 and 2 edges ago
    logic [W-1:0] m_win [D];           // last D filter samples, [0] newest
    logic [W-1:0] m_clean, m_rise, m_fall;
    logic         m_any;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] all_diff;
        if (!reset) begin
            m_r1 = '0; m_r2 = '0;
            for (int j = 0; j < int'(D); j++) m_win[j] = '0;
            m_clean = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
        end else begin
            for (int j = int'(D) - 1; j > 0; j--) m_win[j] = m_win[j-1];
            m_win[0] = m_r2;
            all_diff = '1;
            for (int j = 0; j < int'(D); j++) all_diff &= (m_win[j] ^ m_clean);
            m_clean = m_clean ^ all_diff;
            m_rise  = all_diff & m_clean;
            m_fall  = all_diff & ~m_clean;
            m_any   = |all_diff;
            m_r2 = m_r1;
            m_r1 = s_raw;
        end
    endtask

    // One clock: model steps on the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("s_clean", 32'(s_clean), 32'(m_clean));
        check("s_rise", 32'(s_rise), 32'(m_rise));
        check("s_fall", 32'(s_fall), 32'(m_fall));
        check("any_change", 32'(any_change), 32'(m_any));
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) tick();
    endtask

    // Ticks up to 'limit' edges, returns edge index of first rise on 'bitn'.
    task automatic find_rise(input int unsigned bitn, input int unsigned limit,
                             output int unsigned edge_no);
        edge_no = 0;
        for (int unsigned k = 1; k <= limit; k++) begin
            tick();
            if (s_rise[bitn] && edge_no == 0) edge_no = k;
        end
    endtask

    int unsigned e;
    int unsigned nrise, nfall;
    int unsigned lens [4] = '{3, 7, 2, 5};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        s_raw    = '0;
        reset    = 1'b0;
        m_r1 = '0; m_r2 = '0;
        for (int j = 0; j < int'(D); j++) m_win[j] = '0;
        m_clean = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;

        // Reset values
        @(negedge clk);
        ticks(5);
        check("reset_clean", 32'(s_clean), 32'h0);
        reset = 1'b1;
        ticks(20);
        check("idle_clean", 32'(s_clean), 32'h0);

        // Clean rise on channel 0
        s_raw[0] = 1'b1;
        find_rise(0, 14, e);
        check("rise0_latency", e, D + 2);
        check("rise0_clean", 32'(s_clean), 32'h1);

        // Bounce on channel 1
        nrise = 0; nfall = 0;
        for (int p = 0; p < 4; p++) begin
            s_raw[1] = 1'b1;
            for (int unsigned k = 0; k < lens[p]; k++) begin
                tick(); nrise += 32'(s_rise[1]); nfall += 32'(s_fall[1]);
            end
            s_raw[1] = 1'b0;
            tick(); nrise += 32'(s_rise[1]); nfall += 32'(s_fall[1]);
        end
        s_raw[1] = 1'b1;
        e = 0;
        for (int unsigned k = 1; k <= 14; k++) begin
            tick();
            if (s_rise[1] && e == 0) e = k;
            nrise += 32'(s_rise[1]); nfall += 32'(s_fall[1]);
        end
        check("bounce_latency", e, D + 2);
        check("bounce_nrise", nrise, 1);
        check("bounce_nfall", nfall, 0);

        // Clean fall on channel 2
        s_raw[2] = 1'b1;
        ticks(14);
        s_raw[2] = 1'b0;
        e = 0;
        for (int unsigned k = 1; k <= 14; k++) begin
            tick();
            if (s_fall[2] && e == 0) e = k;
        end
        check("fall2_latency", e, D + 2);
        check("fall2_clean", 32'(s_clean[2]), 32'h0);

        // Simultaneous events
        s_raw = '0;
        ticks(14);
        s_raw = 4'b1010;
        ticks(D + 1);
        check("simul_before", 32'(s_clean), 32'h0);
        tick();
        check("simul_rise", 32'(s_rise), 32'ha);
        check("simul_clean", 32'(s_clean), 32'ha);
        check("simul_any", 32'(any_change), 32'h1);
        tick();
        check("simul_any_off", 32'(any_change), 32'h0);
        s_raw = '0;
        ticks(14);

        // Reset mid-window on channel 3
        s_raw[3] = 1'b1;
        ticks(5);
        reset = 1'b0;
        ticks(2);
        check("midrst_clean", 32'(s_clean), 32'h0);
        reset = 1'b1;
        find_rise(3, 14, e);
        check("midrst_latency", e, D + 2);
        s_raw = '0;
        ticks(14);

        // Randomized stimulus
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) s_raw[$urandom_range(0, W - 1)] ^= 1'b1;
            if ($urandom_range(0, 40) == 0) s_raw = W'($urandom);
            if ($urandom_range(0, 400) == 0) begin
                reset = 1'b0;
                tick();
                tick();
                reset = 1'b1;
            end
            tick();
            if ($urandom_range(0, 30) == 0) ticks($urandom_range(D, 2 * D));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
